// File: rtl/fetch_stage.sv
// RV64 instruction fetch stage: owns the PC, issues in-order requests to instruction
// memory, buffers returned words and drives the IF/ID register toward decode.
module fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0000000000000000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] current_instruction,
  output logic [63:0] addr_current_instruction,
  output logic [63:0] addr_next_instruction,
  output logic        instr_valid
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

  logic [63:0]   req_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] fifo_count;

  logic [63:0]   aq_addr [FIFO_DEPTH];
  logic [PW-1:0] aq_wr;
  logic [PW-1:0] aq_rd;

  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [63:0]   fifo_addr [FIFO_DEPTH];
  logic [PW-1:0] fifo_wr;
  logic [PW-1:0] fifo_rd;

  logic          req_fire;
  logic          resp_drop;
  logic          fifo_push;
  logic          fifo_pop;
  logic [CW:0]   credit_used;
  logic [CW-1:0] outstanding_next;
  logic          unused_target_lsbs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign unused_target_lsbs = ^redirect_target[1:0];

  // Credits cover both in-flight requests and buffered words, so a stalled decode
  // can never cause a returning word to find the buffer full.
  always_comb begin
    credit_used      = {1'b0, outstanding} + {1'b0, fifo_count};
    imem_req_valid   = reset_n && !redirect && (credit_used < DEPTH_C);
    imem_req_addr    = req_pc;
    req_fire         = imem_req_valid && imem_req_ready;
    resp_drop        = imem_resp_valid && (redirect || (drop_count != '0));
    fifo_push        = imem_resp_valid && !resp_drop;
    fifo_pop         = !redirect && !stall && (fifo_count != '0);
    outstanding_next = outstanding + CW'(req_fire) - CW'(imem_resp_valid);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_pc      <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
      aq_wr       <= '0;
      aq_rd       <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      fifo_count  <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (req_fire)        aq_wr <= ptr_inc(aq_wr);
      if (imem_resp_valid) aq_rd <= ptr_inc(aq_rd);
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        req_pc     <= {redirect_target[63:2], 2'b00};
        drop_count <= outstanding_next;
        fifo_wr    <= '0;
        fifo_rd    <= '0;
        fifo_count <= '0;
      end else begin
        if (req_fire) req_pc <= req_pc + 64'd4;
        if (imem_resp_valid && (drop_count != '0)) drop_count <= drop_count - 1'b1;
        if (fifo_push) fifo_wr <= ptr_inc(fifo_wr);
        if (fifo_pop)  fifo_rd <= ptr_inc(fifo_rd);
        fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (req_fire) aq_addr[aq_wr] <= req_pc;
    if (fifo_push) begin
      fifo_data[fifo_wr] <= imem_resp_data;
      fifo_addr[fifo_wr] <= aq_addr[aq_rd];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || redirect) begin
      current_instruction      <= NOP_INSTR;
      addr_current_instruction <= 64'd0;
      addr_next_instruction    <= 64'd4;
      instr_valid              <= 1'b0;
    end else if (!stall) begin
      if (fifo_count != '0) begin
        current_instruction      <= fifo_data[fifo_rd];
        addr_current_instruction <= fifo_addr[fifo_rd];
        addr_next_instruction    <= fifo_addr[fifo_rd] + 64'd4;
        instr_valid              <= 1'b1;
      end else begin
        current_instruction      <= NOP_INSTR;
        addr_current_instruction <= 64'd0;
        addr_next_instruction    <= 64'd4;
        instr_valid              <= 1'b0;
      end
    end
  end

  always @(posedge clock) begin
    if (reset_n && fifo_push && !fifo_pop)
      assert ({1'b0, fifo_count} < DEPTH_C)
        else $fatal(1, "fetch_stage: instruction buffer overflow");
  end

endmodule
